// File: rtl/pin_mode_ctrl.sv
// Button-driven 4-mode LED pattern controller: 2-flop sync + debounce per button, mode FSM, prescaled pattern.
// Pins are registered one cycle after mode/pattern state; no backpressure, outputs are free-running levels.
module pin_mode_ctrl #(
    parameter int DEB_CYCLES = 16384,
    parameter int PRESC_BITS = 20
) (
    input  logic pG0,
    input  logic pRST,
    input  logic p3B1,
    input  logic p3B2,
    output logic p3A0,
    output logic p3A1,
    output logic p3A2,
    output logic p3A3,
    output logic p2A2,
    output logic p2A3
);
    localparam int CW = $clog2(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        MODE_PASS  = 2'd0,
        MODE_COUNT = 2'd1,
        MODE_WALK  = 2'd2,
        MODE_BLINK = 2'd3
    } mode_e;

    // Index 0 is button A (p3B1), index 1 is button B (p3B2); all levels active-low.
    logic [1:0]            sync1_q, sync2_q;
    logic [1:0]            stable_q, stable_d;
    logic [1:0]            press;
    logic [CW-1:0]         cnt_q [2];
    logic [CW-1:0]         cnt_d [2];
    logic [PRESC_BITS-1:0] presc_q, presc_d;
    logic                  tick;
    mode_e                 mode_q, mode_d;
    logic [3:0]            pattern_q, pattern_d;
    logic [3:0]            pins_d, pins_q;
    logic                  frozen_q, frozen_d;
    logic                  frz_out_q, held_out_q;
    logic                  press_a, press_b;

    assign press_a = press[0];
    assign press_b = press[1];

    always_comb begin
        stable_d = stable_q;
        press    = 2'b00;
        cnt_d[0] = '0;
        cnt_d[1] = '0;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i] = sync2_q[i];
                    press[i]    = stable_q[i] & ~sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign tick    = &presc_q;
    assign presc_d = press_a ? '0 : presc_q + 1'b1;

    // FSM: state register
    always_ff @(posedge pG0) begin
        if (pRST) begin
            mode_q <= MODE_PASS;
        end else begin
            mode_q <= mode_d;
        end
    end

    // FSM: next state
    always_comb begin
        mode_d = mode_q;
        if (press_a) begin
            case (mode_q)
                MODE_PASS:  mode_d = MODE_COUNT;
                MODE_COUNT: mode_d = MODE_WALK;
                MODE_WALK:  mode_d = MODE_BLINK;
                default:    mode_d = MODE_PASS;
            endcase
        end
    end

    // FSM: outputs
    always_comb begin
        pins_d = pattern_q;
        if (mode_q == MODE_PASS) begin
            pins_d = {stable_q[1], ~stable_q[1], 1'b0, ~stable_q[0]};
        end
    end

    // A mode change reloads the start value and swallows a coincident tick.
    always_comb begin
        pattern_d = pattern_q;
        if (press_a) begin
            pattern_d = (mode_d == MODE_WALK) ? 4'b0001 : 4'b0000;
        end else if (tick && !frozen_q) begin
            case (mode_q)
                MODE_COUNT: pattern_d = pattern_q + 4'd1;
                MODE_WALK:  pattern_d = {pattern_q[2:0], pattern_q[3]};
                MODE_BLINK: pattern_d = ~pattern_q;
                default:    pattern_d = pattern_q;
            endcase
        end
    end

    assign frozen_d = press_a ? 1'b0 : (press_b ? ~frozen_q : frozen_q);

    always_ff @(posedge pG0) begin
        if (pRST) begin
            sync1_q    <= 2'b11;
            sync2_q    <= 2'b11;
            stable_q   <= 2'b11;
            cnt_q[0]   <= '0;
            cnt_q[1]   <= '0;
            presc_q    <= '0;
            pattern_q  <= 4'b0000;
            frozen_q   <= 1'b0;
            pins_q     <= 4'b0000;
            frz_out_q  <= 1'b0;
            held_out_q <= 1'b0;
        end else begin
            sync1_q    <= {p3B2, p3B1};
            sync2_q    <= sync1_q;
            stable_q   <= stable_d;
            cnt_q[0]   <= cnt_d[0];
            cnt_q[1]   <= cnt_d[1];
            presc_q    <= presc_d;
            pattern_q  <= pattern_d;
            frozen_q   <= frozen_d;
            pins_q     <= pins_d;
            frz_out_q  <= frozen_q;
            held_out_q <= ~stable_q[0];
        end
    end

    assign p3A0 = pins_q[0];
    assign p3A1 = pins_q[1];
    assign p3A2 = pins_q[2];
    assign p3A3 = pins_q[3];
    assign p2A2 = frz_out_q;
    assign p2A3 = held_out_q;

endmodule

// File: tb/tb_pin_mode_ctrl.sv
// Directed bench for pin_mode_ctrl with DEB_CYCLES=4, PRESC_BITS=3; inputs driven and outputs sampled on negedges.
module tb_pin_mode_ctrl;
    logic pG0 = 1'b0;
    logic pRST, p3B1, p3B2;
    logic p3A0, p3A1, p3A2, p3A3, p2A2, p2A3;
    logic [3:0] pins;
    int n_checks = 0;
    int n_fail = 0;

    assign pins = {p3A3, p3A2, p3A1, p3A0};

    always #5 pG0 = ~pG0;

    pin_mode_ctrl #(.DEB_CYCLES(4), .PRESC_BITS(3)) dut (
        .pG0(pG0), .pRST(pRST), .p3B1(p3B1), .p3B2(p3B2),
        .p3A0(p3A0), .p3A1(p3A1), .p3A2(p3A2), .p3A3(p3A3),
        .p2A2(p2A2), .p2A3(p2A3)
    );

    task automatic step(input int n);
        repeat (n) @(negedge pG0);
    endtask

    // Holds the selected buttons low for n sampling edges, then releases them.
    task automatic press(input logic a, input logic b, input int n);
        if (a) p3B1 = 1'b0;
        if (b) p3B2 = 1'b0;
        step(n);
        p3B1 = 1'b1;
        p3B2 = 1'b1;
    endtask

    task automatic do_reset;
        pRST = 1'b1;
        step(2);
        pRST = 1'b0;
        step(1);
    endtask

    task automatic test_reset;
        pRST = 1'b1;
        step(2);
        n_checks++;
        if ({pins, p2A2, p2A3} !== 6'b000000) begin
            n_fail++;
            $display("FAIL reset_hold: got %b want 000000", {pins, p2A2, p2A3});
        end
        pRST = 1'b0;
        step(1);
        n_checks++;
        if ({pins, p2A2, p2A3} !== 6'b100000) begin
            n_fail++;
            $display("FAIL reset_exit: got %b want 100000", {pins, p2A2, p2A3});
        end
    endtask

    task automatic test_short_press;
        press(1'b1, 1'b0, 3);
        for (int i = 0; i < 10; i++) begin
            step(1);
            n_checks++;
            if ({pins, p2A2, p2A3} !== 6'b100000) begin
                n_fail++;
                $display("FAIL short_press[%0d]: got %b want 100000", i, {pins, p2A2, p2A3});
            end
        end
    endtask

    task automatic test_count;
        press(1'b1, 1'b0, 10);
        n_checks++;
        if ({pins, p2A2, p2A3} !== 6'b000001) begin
            n_fail++;
            $display("FAIL count_enter: got %b want 000001", {pins, p2A2, p2A3});
        end
        step(5);
        for (int k = 1; k <= 16; k++) begin
            logic [3:0] exp_cnt;
            exp_cnt = 4'(k);
            n_checks++;
            if (pins !== exp_cnt) begin
                n_fail++;
                $display("FAIL count_step[%0d]: got %b want %b", k, pins, exp_cnt);
            end
            step(8);
        end
        n_checks++;
        if (p2A3 !== 1'b0) begin
            n_fail++;
            $display("FAIL count_release_held: got %b want 0", p2A3);
        end
    endtask

    task automatic test_mode_wrap;
        do_reset();
        press(1'b1, 1'b0, 7);
        n_checks++;
        if (pins !== 4'b0000) begin n_fail++; $display("FAIL wrap_count_start: got %b want 0000", pins); end
        step(8);
        n_checks++;
        if (pins !== 4'b0001) begin n_fail++; $display("FAIL wrap_count_tick: got %b want 0001", pins); end
        step(8);
        press(1'b1, 1'b0, 7);
        n_checks++;
        if (pins !== 4'b0001) begin n_fail++; $display("FAIL wrap_walk_start: got %b want 0001", pins); end
        step(8);
        n_checks++;
        if (pins !== 4'b0010) begin n_fail++; $display("FAIL wrap_walk_tick1: got %b want 0010", pins); end
        step(8);
        n_checks++;
        if (pins !== 4'b0100) begin n_fail++; $display("FAIL wrap_walk_tick2: got %b want 0100", pins); end
        press(1'b1, 1'b0, 7);
        n_checks++;
        if (pins !== 4'b0000) begin n_fail++; $display("FAIL wrap_blink_start: got %b want 0000", pins); end
        step(8);
        n_checks++;
        if (pins !== 4'b1111) begin n_fail++; $display("FAIL wrap_blink_tick1: got %b want 1111", pins); end
        step(8);
        n_checks++;
        if (pins !== 4'b0000) begin n_fail++; $display("FAIL wrap_blink_tick2: got %b want 0000", pins); end
        press(1'b1, 1'b0, 7);
        n_checks++;
        if ({pins, p2A3} !== 5'b10011) begin
            n_fail++;
            $display("FAIL wrap_pass_held: got %b want 10011", {pins, p2A3});
        end
        step(7);
        n_checks++;
        if ({pins, p2A3} !== 5'b10000) begin
            n_fail++;
            $display("FAIL wrap_pass_released: got %b want 10000", {pins, p2A3});
        end
    endtask

    task automatic test_freeze;
        step(2);
        press(1'b1, 1'b0, 7);
        step(8);
        press(1'b1, 1'b0, 7);
        step(16);
        n_checks++;
        if (pins !== 4'b0100) begin n_fail++; $display("FAIL freeze_setup: got %b want 0100", pins); end
        press(1'b0, 1'b1, 7);
        n_checks++;
        if ({pins, p2A2} !== 5'b01001) begin
            n_fail++;
            $display("FAIL freeze_on: got %b want 01001", {pins, p2A2});
        end
        for (int i = 0; i < 3; i++) begin
            step(8);
            n_checks++;
            if ({pins, p2A2} !== 5'b01001) begin
                n_fail++;
                $display("FAIL freeze_hold[%0d]: got %b want 01001", i, {pins, p2A2});
            end
        end
        press(1'b0, 1'b1, 7);
        n_checks++;
        if ({pins, p2A2} !== 5'b01000) begin
            n_fail++;
            $display("FAIL freeze_off: got %b want 01000", {pins, p2A2});
        end
        step(2);
        n_checks++;
        if (pins !== 4'b1000) begin n_fail++; $display("FAIL unfreeze_tick1: got %b want 1000", pins); end
        step(8);
        n_checks++;
        if (pins !== 4'b0001) begin n_fail++; $display("FAIL unfreeze_tick2: got %b want 0001", pins); end
    endtask

    task automatic test_back_to_back;
        do_reset();
        press(1'b1, 1'b0, 7);
        step(8);
        n_checks++;
        if (pins !== 4'b0001) begin n_fail++; $display("FAIL b2b_count: got %b want 0001", pins); end
        press(1'b0, 1'b1, 7);
        n_checks++;
        if ({pins, p2A2} !== 5'b00011) begin
            n_fail++;
            $display("FAIL b2b_frozen: got %b want 00011", {pins, p2A2});
        end
        step(8);
        n_checks++;
        if ({pins, p2A2} !== 5'b00011) begin
            n_fail++;
            $display("FAIL b2b_frozen_hold: got %b want 00011", {pins, p2A2});
        end
        press(1'b1, 1'b1, 7);
        n_checks++;
        if ({pins, p2A2} !== 5'b00010) begin
            n_fail++;
            $display("FAIL b2b_both_pressed: got %b want 00010", {pins, p2A2});
        end
        step(8);
        n_checks++;
        if ({pins, p2A2} !== 5'b00100) begin
            n_fail++;
            $display("FAIL b2b_walk_tick: got %b want 00100", {pins, p2A2});
        end
    endtask

    task automatic test_reset_mid_debounce;
        step(8);
        p3B1 = 1'b0;
        step(4);
        pRST = 1'b1;
        step(2);
        n_checks++;
        if ({pins, p2A2, p2A3} !== 6'b000000) begin
            n_fail++;
            $display("FAIL midreset_hold: got %b want 000000", {pins, p2A2, p2A3});
        end
        pRST = 1'b0;
        step(3);
        p3B1 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1);
            n_checks++;
            if ({pins, p2A2, p2A3} !== 6'b100000) begin
                n_fail++;
                $display("FAIL midreset_nopress[%0d]: got %b want 100000", i, {pins, p2A2, p2A3});
            end
        end
    endtask

    initial begin
        pRST = 1'b1;
        p3B1 = 1'b1;
        p3B2 = 1'b1;
        @(negedge pG0);
        test_reset();
        test_short_press();
        test_count();
        test_mode_wrap();
        test_freeze();
        test_back_to_back();
        test_reset_mid_debounce();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
